// File: rtl/code_conv_scheduler.sv
// ---------------------------------------------------------------------------
// code_conv_scheduler
//
// Shares one binary<->gray conversion engine between two requesters with
// round-robin arbitration. One word is in flight at a time:
//   IDLE : arbitrate and accept one request
//   CONV : convert (1 cycle for binary->gray, WIDTH cycles for gray->binary)
//   HOLD : present the registered result until the consumer takes it
//
// Handshake rule, applied to every port: a transfer happens on a rising clock
// edge where valid and ready are both high. valid never waits on ready, and
// once out_valid is raised the result stays stable until it is taken.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req0_valid/ready      requester 0 handshake (ready is combinational)
//   req0_data, req0_mode  requester 0 word and mode (0: bin->gray, 1: gray->bin)
//   req1_valid/ready      requester 1 handshake (ready is combinational)
//   req1_data, req1_mode  requester 1 word and mode
//   out_valid/ready       result handshake
//   out_data              converted word (registered, updates only on CONV->HOLD)
//   out_id                requester that issued the result
//   out_mode              mode of the result
//   busy                  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module code_conv_scheduler #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic             out_mode,
    output logic             busy
);

    // Iteration counter must be able to hold 0..WIDTH.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // Arbitration
    logic             last_grant;
    logic             grant;
    logic             accept;

    // Captured request and conversion working registers
    logic [WIDTH-1:0] src_q;     // captured word; shifted left in gray->binary mode
    logic             mode_q;
    logic             id_q;
    logic [CW-1:0]    cnt_q;
    logic             par_q;     // running XOR of gray bits seen so far (= last binary bit)
    logic [WIDTH-1:0] acc_q;     // binary bits resolved so far, MSB first

    logic [WIDTH-1:0] gray_val;
    logic             par_nxt;
    logic [WIDTH-1:0] acc_nxt;
    logic             conv_done;

    // -----------------------------------------------------------------------
    // Arbitration: a lone requester wins; on contention the requester that
    // did not win last time is granted. last_grant resets to 1 so requester 0
    // wins the first contention.
    // -----------------------------------------------------------------------
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
        req0_ready = (state == IDLE) && req0_valid && !grant;
        req1_ready = (state == IDLE) && req1_valid &&  grant;
        accept     = req0_ready || req1_ready;
    end

    // -----------------------------------------------------------------------
    // Conversion datapath.
    // binary->gray is a single XOR with the word shifted right (MSB passes
    // through because a zero is shifted in).
    // gray->binary walks the captured word MSB first: each cycle the top gray
    // bit is XORed into the running parity, which is exactly the next binary
    // bit, and that bit is shifted into the accumulator. After WIDTH cycles
    // the accumulator holds the full binary word in natural bit order.
    // -----------------------------------------------------------------------
    always_comb begin
        gray_val  = src_q ^ (src_q >> 1);
        par_nxt   = par_q ^ src_q[WIDTH-1];
        acc_nxt   = (acc_q << 1) | WIDTH'(par_nxt);
        conv_done = !mode_q || (cnt_q == CW'(WIDTH - 1));
    end

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                // New requests are only considered once back in IDLE, so a
                // result handshake and a new accept never share a cycle.
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy      = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            src_q      <= '0;
            mode_q     <= 1'b0;
            id_q       <= 1'b0;
            cnt_q      <= '0;
            par_q      <= 1'b0;
            acc_q      <= '0;
            out_data   <= '0;
            out_id     <= 1'b0;
            out_mode   <= 1'b0;
        end else begin
            if (accept) begin
                src_q      <= grant ? req1_data : req0_data;
                mode_q     <= grant ? req1_mode : req0_mode;
                id_q       <= grant;
                last_grant <= grant;
                cnt_q      <= '0;
                par_q      <= 1'b0;
                acc_q      <= '0;
            end else if (state == CONV) begin
                if (mode_q) begin
                    src_q <= src_q << 1;
                    par_q <= par_nxt;
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_q + CW'(1);
                end
                // The output register is only written with a finished word.
                if (conv_done) begin
                    out_data <= mode_q ? acc_nxt : gray_val;
                    out_id   <= id_q;
                    out_mode <= mode_q;
                end
            end
        end
    end

endmodule

// File: doc/code_conv_scheduler.md
Name: code_conv_scheduler

Overview:
Shares one iterative binary/gray code-conversion engine between two requesters using round-robin arbitration. Each request carries a data word and a mode bit (binary->gray or gray->binary). The result is returned on a single valid/ready output port, tagged with the requester ID. The block sits between producers of pointers or counters and downstream logic that needs the converted code.

Parameters:
WIDTH, 4, data word width in bits (legal range >= 1)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  reset; asynchronous, active-low
req0_valid  input  1  requester 0 has a word to convert
req0_ready  output  1  requester 0 word accepted this cycle
req0_data  input  WIDTH  requester 0 word
req0_mode  input  1  0 = binary->gray, 1 = gray->binary
req1_valid  input  1  requester 1 has a word to convert
req1_ready  output  1  requester 1 word accepted this cycle
req1_data  input  WIDTH  requester 1 word
req1_mode  input  1  0 = binary->gray, 1 = gray->binary
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  converted word
out_id  output  1  requester that issued the result
out_mode  output  1  mode of the result
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset is asynchronous and active-low. Clock and reset are named clk and rst_n. While rst_n is low: state=IDLE, out_valid=0, out_data=0, out_id=0, out_mode=0, busy=0, last_grant=1 (requester 0 wins the first contention). Any in-flight conversion is discarded.
- FSM states: IDLE, CONV, HOLD.
- IDLE:
  - grant = the only valid requester; if both are valid, the requester != last_grant.
  - reqN_ready = (state==IDLE) && reqN_valid && (grant==N). It is combinational, and at most one ready is high.
  - On accept: capture data, mode and ID; set last_grant=N; set the iteration counter to 0; go to CONV.
  - With no valid requester, stay in IDLE and leave last_grant unchanged.
- CONV, mode 0 (binary->gray):
  - gray = b ^ (b >> 1), with the MSB passed through.
  - Computed in exactly 1 cycle, then go to HOLD.
- CONV, mode 1 (gray->binary):
  - Computed bit-serially, MSB first, one bit per cycle.
  - Cycle k (k = 0..WIDTH-1) resolves bit WIDTH-1-k: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
  - Takes WIDTH cycles, then go to HOLD.
  - The counter is ceil(log2(WIDTH+1)) bits.
- Latency, counted from the accept edge E0:
  - out_valid rises after edge E1 for mode 0.
  - out_valid rises after edge E_WIDTH for mode 1.
  - For WIDTH = 1 both modes take 1 cycle (output = input).
- HOLD:
  - out_valid=1; out_data, out_id and out_mode are registered and held stable.
  - When out_valid && out_ready: drop out_valid and go to IDLE.
  - A new request is not accepted in the same cycle as the output handshake. Maximum throughput is one word per (latency + 2) cycles.
- out_ready is ignored outside HOLD. Requester inputs are ignored outside IDLE, and reqN_ready=0 there.
- Simultaneous valids when last_grant=0: requester 1 is granted, then requester 0 next, strictly alternating while both stay valid.
- A requester that drops valid before being granted is not accepted, and no state changes.
- out_data never shows partial results; it updates only on the CONV->HOLD transition.
- rst_n asserted mid-CONV or mid-HOLD returns the block to reset values immediately (asynchronously), and the pending result is lost.

Test Plan:
1. WIDTH=4. req0 valid, data=4'b1011, mode=0 -> req0_ready high for 1 cycle; out_valid 1 cycle after accept; out_data=4'b1110, out_id=0, out_mode=0.
2. req1 valid, data=4'b1110, mode=1 -> out_valid exactly 4 cycles after accept; out_data=4'b1011, out_id=1, busy high from accept through the output handshake.
3. req0 and req1 both held valid from reset with 5 words each -> grants alternate 0,1,0,1...; first grant is 0; out_id sequence is 0,1,0,1,...
4. Backpressure: out_ready=0 for 10 cycles in HOLD with result 4'b0110 -> out_valid and out_data stay constant; both req_ready stay low; one cycle after out_ready=1 the block is back in IDLE.
5. rst_n pulsed low during cycle 2 of a mode-1 conversion -> out_valid=0, busy=0 immediately; no result is emitted; the next request is granted to req0.
6. Exhaustive, all 16 values, both modes, random valid and out_ready -> mode 1 of (mode 0 of x) equals x; every accepted word produces exactly one result with the correct out_id.
